// File: rtl/seq_alu.sv
// Handshaked ALU: ADD/OR/XOR/AND/LT/EQ in one cycle, SLL/SRL on a one-bit-per-cycle shifter.
// Define SEQ_ALU_BARREL_EN to replace the iterative shifter with a single-cycle barrel shifter.
module seq_alu #(
    parameter int W  = 8,
    parameter int CW = $clog2(W)
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] ina,
    input  logic [W-1:0] inb,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         carry
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_LT  = 3'b100;
    localparam logic [2:0] OP_EQ  = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRL = 3'b111;

    logic         valid_q, valid_d;
    logic [W-1:0] res_q, res_d;
    logic         zero_q, zero_d;
    logic         carry_q, carry_d;
    logic [W:0]   sum;
    logic [W-1:0] alu_res;
    logic         alu_carry;
    logic         accept;

    assign sum = {1'b0, ina} + {1'b0, inb};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res   = sum[W-1:0];
                alu_carry = sum[W];
            end
            OP_OR:  alu_res = ina | inb;
            OP_XOR: alu_res = ina ^ inb;
            OP_AND: alu_res = ina & inb;
            OP_LT:  alu_res = {{(W-1){1'b0}}, (ina < inb)};
            OP_EQ:  alu_res = {{(W-1){1'b0}}, (ina == inb)};
`ifdef SEQ_ALU_BARREL_EN
            OP_SLL: alu_res = ina << inb;
            OP_SRL: alu_res = ina >> inb;
`else
            // Only the k==0 and k>=W shift cases finish in one cycle here
            OP_SLL: alu_res = (inb == '0) ? ina : '0;
            OP_SRL: alu_res = (inb == '0) ? ina : '0;
`endif
            default: alu_res = '0;
        endcase
    end

`ifdef SEQ_ALU_BARREL_EN
    assign in_ready = !Reset && (!valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        if (valid_q && out_ready) valid_d = 1'b0;
        if (accept) begin
            res_d   = alu_res;
            zero_d  = (alu_res == '0);
            carry_d = alu_carry;
            valid_d = 1'b1;
        end
    end
`else
    typedef enum logic {IDLE, SHIFT} state_t;
    localparam logic [W-1:0] W_VAL = W'(W);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  work_q, work_d;
    logic          dir_q, dir_d;
    logic          slow_shift;
    logic [W-1:0]  shift_nxt;

    assign in_ready   = !Reset && (state_q == IDLE) && (!valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign slow_shift = (op[2:1] == 2'b11) && (inb != '0) && (inb < W_VAL);
    assign shift_nxt  = dir_q ? (work_q >> 1) : (work_q << 1);

    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        zero_d  = zero_q;
        carry_d = carry_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        dir_d   = dir_q;
        if (valid_q && out_ready) valid_d = 1'b0;
        if (state_q == SHIFT) begin
            work_d = shift_nxt;
            cnt_d  = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                res_d   = shift_nxt;
                zero_d  = (shift_nxt == '0);
                carry_d = 1'b0;
                valid_d = 1'b1;
                state_d = IDLE;
            end
        end else if (accept) begin
            if (slow_shift) begin
                work_d  = ina;
                cnt_d   = inb[CW-1:0];
                dir_d   = op[0];
                state_d = SHIFT;
            end else begin
                res_d   = alu_res;
                zero_d  = (alu_res == '0);
                carry_d = alu_carry;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            work_q  <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            dir_q   <= dir_d;
        end
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = res_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (W=8): directed cases plus randomized ops against an arithmetic model.
module tb_seq_alu;
    localparam int W = 8;
`ifdef SEQ_ALU_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] ina;
    logic [7:0] inb;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       carry;

    int tests = 0;
    int fails = 0;

    always #5 Clk = ~Clk;

    seq_alu #(.W(W)) dut (
        .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .ina(ina), .inb(inb), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry)
    );

    function automatic void model(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] r, output logic c, output int lat);
        int s;
        lat = 1;
        c   = 1'b0;
        r   = 8'h00;
        case (o)
            3'd0: begin
                s = int'(a) + int'(b);
                r = 8'(s % 256);
                c = (s >= 256);
            end
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = a & b;
            3'd4: r = (int'(a) < int'(b)) ? 8'd1 : 8'd0;
            3'd5: r = (int'(a) == int'(b)) ? 8'd1 : 8'd0;
            3'd6: begin
                r = (int'(b) >= 8) ? 8'd0 : 8'((int'(a) * (1 << int'(b))) % 256);
                if (!BARREL && int'(b) >= 1 && int'(b) <= 7) lat = int'(b) + 1;
            end
            default: begin
                r = (int'(b) >= 8) ? 8'd0 : 8'(int'(a) / (1 << int'(b)));
                if (!BARREL && int'(b) >= 1 && int'(b) <= 7) lat = int'(b) + 1;
            end
        endcase
    endfunction

    task automatic issue(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge Clk); #1;
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
        end
        in_valid = 1'b1; op = o; ina = a; inb = b;
        @(posedge Clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge Clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 3'd0; ina = 8'h00; inb = 8'h00;
        repeat (3) @(posedge Clk);
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready);
        end
        tests++;
        if ({out_valid, result, zero, carry} !== 11'd0) begin
            fails++;
            $display("FAIL reset_outputs got v=%b r=%h z=%b c=%b exp all 0", out_valid, result, zero, carry);
        end
        Reset = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_add();
        int lat;
        out_ready = 1'b1;
        issue(3'd0, 8'hF0, 8'h20);
        wait_valid(lat);
        tests++;
        if (lat !== 1 || result !== 8'h10 || carry !== 1'b1 || zero !== 1'b0) begin
            fails++;
            $display("FAIL add_carry got lat=%0d r=%h c=%b z=%b exp lat=1 r=10 c=1 z=0", lat, result, carry, zero);
        end
        @(posedge Clk); #1;
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL add_consume out_valid=%b exp=0", out_valid);
        end
    endtask

    task automatic test_shift();
        int lat;
        int lows;
        out_ready = 1'b1;
        issue(3'd6, 8'h01, 8'd3);
        lat = 1; lows = 0;
        while (!out_valid && lat < 100) begin
            if (!in_ready) lows++;
            @(posedge Clk); #1;
            lat++;
        end
        tests++;
        if (lat !== (BARREL ? 1 : 4) || lows !== (BARREL ? 0 : 3) || result !== 8'h08) begin
            fails++;
            $display("FAIL sll3 got lat=%0d busy=%0d r=%h exp lat=%0d busy=%0d r=08",
                     lat, lows, result, BARREL ? 1 : 4, BARREL ? 0 : 3);
        end
        issue(3'd7, 8'hFF, 8'd9);
        wait_valid(lat);
        tests++;
        if (lat !== 1 || result !== 8'h00 || zero !== 1'b1 || carry !== 1'b0) begin
            fails++;
            $display("FAIL srl9 got lat=%0d r=%h z=%b c=%b exp lat=1 r=00 z=1 c=0", lat, result, zero, carry);
        end
        issue(3'd5, 8'h5A, 8'h5A);
        wait_valid(lat);
        tests++;
        if (lat !== 1 || result !== 8'h01 || zero !== 1'b0) begin
            fails++;
            $display("FAIL eq got lat=%0d r=%h z=%b exp lat=1 r=01 z=0", lat, result, zero);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_backpressure();
        int lat;
        logic [7:0] a, b, exp;
        a = 8'($urandom); b = 8'($urandom);
        exp = a ^ b;
        out_ready = 1'b0;
        issue(3'd2, a, b);
        wait_valid(lat);
        tests++;
        if (lat !== 1 || result !== exp) begin
            fails++; $display("FAIL bp_xor got lat=%0d r=%h exp lat=1 r=%h", lat, result, exp);
        end
        in_valid = 1'b1; op = 3'd0; ina = 8'h03; inb = 8'h04;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (result !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold%0d got r=%h rdy=%b v=%b exp r=%h rdy=0 v=1", i, result, in_ready, out_valid, exp);
            end
            @(posedge Clk); #1;
        end
        out_ready = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release_ready got=%b exp=1", in_ready);
        end
        @(posedge Clk); #1;
        in_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || result !== 8'h07) begin
            fails++; $display("FAIL bp_same_edge got v=%b r=%h exp v=1 r=07", out_valid, result);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b, r;
        logic c;
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            model(3'd0, a, b, r, c, lat);
            in_valid = 1'b1; op = 3'd0; ina = a; inb = b;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready);
            end
            @(posedge Clk); #1;
            tests++;
            if (out_valid !== 1'b1 || result !== r || carry !== c) begin
                fails++;
                $display("FAIL b2b_result%0d got v=%b r=%h c=%b exp v=1 r=%h c=%b", i, out_valid, result, carry, r, c);
            end
        end
        in_valid = 1'b0;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset_mid_shift();
        int lat;
        int seen = 0;
        out_ready = 1'b1;
        issue(3'd6, 8'h03, 8'd5);
        @(posedge Clk); #1;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL rst_mid_after got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge Clk); #1;
            if (out_valid) seen++;
        end
        tests++;
        if (seen !== 0) begin
            fails++; $display("FAIL rst_mid_abort got %0d valid cycles exp 0", seen);
        end
        issue(3'd1, 8'h0F, 8'hF0);
        wait_valid(lat);
        tests++;
        if (lat !== 1 || result !== 8'hFF || zero !== 1'b0) begin
            fails++; $display("FAIL rst_mid_or got lat=%0d r=%h z=%b exp lat=1 r=ff z=0", lat, result, zero);
        end
        @(posedge Clk); #1;
    endtask

    task automatic test_random();
        logic [2:0] o;
        logic [7:0] a, b, r;
        logic c;
        int elat, lat, hold;
        for (int i = 0; i < 60; i++) begin
            o = 3'($urandom_range(0, 7));
            a = 8'($urandom);
            b = (o[2:1] == 2'b11) ? 8'($urandom_range(0, 10)) : 8'($urandom);
            if (o == 3'd5 && $urandom_range(0, 2) == 0) b = a;
            model(o, a, b, r, c, elat);
            hold = $urandom_range(0, 2);
            out_ready = 1'b0;
            issue(o, a, b);
            wait_valid(lat);
            tests++;
            if (lat !== elat || result !== r || carry !== c || zero !== (r == 8'h00)) begin
                fails++;
                $display("FAIL rand%0d op=%0d a=%h b=%h got lat=%0d r=%h c=%b z=%b exp lat=%0d r=%h c=%b z=%b",
                         i, o, a, b, lat, result, carry, zero, elat, r, c, (r == 8'h00));
            end
            if (hold > 0) begin
                repeat (hold) @(posedge Clk);
                #1;
                tests++;
                if (out_valid !== 1'b1 || result !== r) begin
                    fails++; $display("FAIL rand_hold%0d got v=%b r=%h exp v=1 r=%h", i, out_valid, result, r);
                end
            end
            out_ready = 1'b1;
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
